// File: rtl/regbus_pkg.sv
// regbus_pkg
// Shared definitions for the register-bus initiator: the controller state
// enum, the default bus widths and the saturation limit of the timeout
// error counter.
package regbus_pkg;

    typedef enum logic [2:0] {
        IDLE,
        WR,
        RD,
        RD_WAIT,
        RSP
    } state_e;

    localparam int DEF_ADDR_W  = 16;
    localparam int DEF_DATA_W  = 32;
    localparam int ERR_CNT_MAX = 255;

endpackage

// File: rtl/regbus_tmo_cnt.sv
// regbus_tmo_cnt
// Read-timeout counter plus saturating count of timeouts.
// Ports:
//   clk, rstb   clock, asynchronous active-low reset
//   clear_i     restart the wait counter (issued with the read strobe)
//   enable_i    one more cycle spent waiting for read data
//   hit_i       a timeout happened; bump the error count
//   expired_o   this waiting cycle is the TIMEOUT-th one
//   err_cnt_o   number of timeouts seen, saturating at ERR_CNT_MAX
module regbus_tmo_cnt
    import regbus_pkg::*;
#(
    parameter int TIMEOUT = 15
) (
    input  logic       clk,
    input  logic       rstb,
    input  logic       clear_i,
    input  logic       enable_i,
    input  logic       hit_i,
    output logic       expired_o,
    output logic [7:0] err_cnt_o
);

    logic [7:0] cnt_q, cnt_d;
    logic [7:0] err_cnt_q, err_cnt_d;

    // cnt_q holds the number of waiting cycles already completed, so the
    // current waiting cycle is the last allowed one when it equals TIMEOUT-1.
    assign expired_o = enable_i && (cnt_q == 8'(TIMEOUT - 1));
    assign err_cnt_o = err_cnt_q;

    always_comb begin
        cnt_d     = cnt_q;
        err_cnt_d = err_cnt_q;
        if (clear_i) begin
            cnt_d = '0;
        end else if (enable_i) begin
            cnt_d = cnt_q + 8'd1;
        end
        if (hit_i && (err_cnt_q != 8'(ERR_CNT_MAX))) begin
            err_cnt_d = err_cnt_q + 8'd1;
        end
    end

    always_ff @(posedge clk or negedge rstb) begin
        if (!rstb) begin
            cnt_q     <= '0;
            err_cnt_q <= '0;
        end else begin
            cnt_q     <= cnt_d;
            err_cnt_q <= err_cnt_d;
        end
    end

endmodule

// File: rtl/regbus_master.sv
// regbus_master
// Register-bus initiator: takes one command at a time from a valid/ready
// stream, performs it on the register file's write or read port, and
// returns the result on a valid/ready response stream. Reads that see no
// rd_rdy within TIMEOUT waiting cycles complete with rsp_err set.
// Ports:
//   clk, rstb                          clock, asynchronous active-low reset
//   cmd_valid/cmd_ready                command handshake
//   cmd_write/addr/be/wdata            command payload
//   rsp_valid/rsp_ready                response handshake
//   rsp_write/rsp_rdata/rsp_err        response payload
//   err_cnt                            saturating timeout count
//   wr_en/be/wr_addr/wdata             register-file write port
//   rd_en/rd_addr, rdata/rd_rdy        register-file read port and return
// Every output comes straight from a flop.
module regbus_master
    import regbus_pkg::*;
#(
    parameter int ADDR_W  = DEF_ADDR_W,
    parameter int DATA_W  = DEF_DATA_W,
    parameter int TIMEOUT = 15
) (
    input  logic                  clk,
    input  logic                  rstb,
    input  logic                  cmd_valid,
    output logic                  cmd_ready,
    input  logic                  cmd_write,
    input  logic [ADDR_W-1:0]     cmd_addr,
    input  logic [DATA_W/8-1:0]   cmd_be,
    input  logic [DATA_W-1:0]     cmd_wdata,
    output logic                  rsp_valid,
    input  logic                  rsp_ready,
    output logic                  rsp_write,
    output logic [DATA_W-1:0]     rsp_rdata,
    output logic                  rsp_err,
    output logic [7:0]            err_cnt,
    output logic                  wr_en,
    output logic [DATA_W/8-1:0]   be,
    output logic [ADDR_W-1:0]     wr_addr,
    output logic [DATA_W-1:0]     wdata,
    output logic                  rd_en,
    output logic [ADDR_W-1:0]     rd_addr,
    input  logic [DATA_W-1:0]     rdata,
    input  logic                  rd_rdy
);

    localparam int BE_W = DATA_W / 8;

    state_e              state_q, state_d;
    logic                cmd_ready_q, cmd_ready_d;
    logic                rsp_valid_q, rsp_valid_d;
    logic                rsp_write_q, rsp_write_d;
    logic [DATA_W-1:0]   rsp_rdata_q, rsp_rdata_d;
    logic                rsp_err_q, rsp_err_d;
    logic                wr_en_q, wr_en_d;
    logic                rd_en_q, rd_en_d;
    logic [BE_W-1:0]     be_q, be_d;
    logic [ADDR_W-1:0]   wr_addr_q, wr_addr_d;
    logic [DATA_W-1:0]   wdata_q, wdata_d;
    logic [ADDR_W-1:0]   rd_addr_q, rd_addr_d;

    logic                tmo_clear;
    logic                tmo_enable;
    logic                tmo_hit;
    logic                tmo_expired;

    regbus_tmo_cnt #(
        .TIMEOUT (TIMEOUT)
    ) u_tmo_cnt (
        .clk       (clk),
        .rstb      (rstb),
        .clear_i   (tmo_clear),
        .enable_i  (tmo_enable),
        .hit_i     (tmo_hit),
        .expired_o (tmo_expired),
        .err_cnt_o (err_cnt)
    );

    // The command payload is loaded straight into the port registers, which
    // double as the holding registers; they keep their value between
    // transactions. The strobes and handshake flags are derived from the
    // next state so that they are registered yet line up with the state.
    always_comb begin
        state_d     = state_q;
        rsp_write_d = rsp_write_q;
        rsp_rdata_d = rsp_rdata_q;
        rsp_err_d   = rsp_err_q;
        be_d        = be_q;
        wr_addr_d   = wr_addr_q;
        wdata_d     = wdata_q;
        rd_addr_d   = rd_addr_q;
        tmo_clear   = 1'b0;
        tmo_enable  = 1'b0;
        tmo_hit     = 1'b0;

        case (state_q)
            IDLE: begin
                // cmd_ready_q is low in the first cycle after reset, so
                // acceptance is gated on the registered ready, not the state.
                if (cmd_ready_q && cmd_valid) begin
                    if (cmd_write) begin
                        be_d      = cmd_be;
                        wr_addr_d = cmd_addr;
                        wdata_d   = cmd_wdata;
                        state_d   = WR;
                    end else begin
                        rd_addr_d = cmd_addr;
                        state_d   = RD;
                    end
                end
            end
            WR: begin
                rsp_write_d = 1'b1;
                rsp_rdata_d = '0;
                rsp_err_d   = 1'b0;
                state_d     = RSP;
            end
            RD: begin
                tmo_clear = 1'b1;
                state_d   = RD_WAIT;
            end
            RD_WAIT: begin
                // Data arriving on the last allowed cycle still wins.
                tmo_enable = !rd_rdy;
                if (rd_rdy) begin
                    rsp_write_d = 1'b0;
                    rsp_rdata_d = rdata;
                    rsp_err_d   = 1'b0;
                    state_d     = RSP;
                end else if (tmo_expired) begin
                    tmo_hit     = 1'b1;
                    rsp_write_d = 1'b0;
                    rsp_rdata_d = '0;
                    rsp_err_d   = 1'b1;
                    state_d     = RSP;
                end
            end
            RSP: begin
                if (rsp_ready) begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        cmd_ready_d = (state_d == IDLE);
        wr_en_d     = (state_d == WR);
        rd_en_d     = (state_d == RD);
        rsp_valid_d = (state_d == RSP);
    end

    always_ff @(posedge clk or negedge rstb) begin
        if (!rstb) begin
            state_q     <= IDLE;
            cmd_ready_q <= 1'b0;
            rsp_valid_q <= 1'b0;
            rsp_write_q <= 1'b0;
            rsp_rdata_q <= '0;
            rsp_err_q   <= 1'b0;
            wr_en_q     <= 1'b0;
            rd_en_q     <= 1'b0;
            be_q        <= '0;
            wr_addr_q   <= '0;
            wdata_q     <= '0;
            rd_addr_q   <= '0;
        end else begin
            state_q     <= state_d;
            cmd_ready_q <= cmd_ready_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_write_q <= rsp_write_d;
            rsp_rdata_q <= rsp_rdata_d;
            rsp_err_q   <= rsp_err_d;
            wr_en_q     <= wr_en_d;
            rd_en_q     <= rd_en_d;
            be_q        <= be_d;
            wr_addr_q   <= wr_addr_d;
            wdata_q     <= wdata_d;
            rd_addr_q   <= rd_addr_d;
        end
    end

    assign cmd_ready = cmd_ready_q;
    assign rsp_valid = rsp_valid_q;
    assign rsp_write = rsp_write_q;
    assign rsp_rdata = rsp_rdata_q;
    assign rsp_err   = rsp_err_q;
    assign wr_en     = wr_en_q;
    assign rd_en     = rd_en_q;
    assign be        = be_q;
    assign wr_addr   = wr_addr_q;
    assign wdata     = wdata_q;
    assign rd_addr   = rd_addr_q;

endmodule
